pmt_pulse_conditioner: RTL and testbench

Front-end stage between the raw photomultiplier discriminator output and the photon counter. Samples the asynchronous PMT pulse train into the system clock domain, detects rising edges, enforces a programmable dead time, and tags each accepted photon with the light-source phase at acceptance time. Tagged photons are buffered in per-phase saturating pending counters and delivered one token per transfer over a valid/ready stream, so the counter's add/subtract logic can stall without losing photons.

---
 rtl/pmt_pulse_conditioner.sv | 210 +++++++++++++++++++++
 tb/tb_pmt_pulse_conditioner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmt_pulse_conditioner.sv
// pmt_pulse_conditioner
// Synchronizes the raw PMT discriminator pulse, detects rising edges, applies a
// programmable dead time, tags accepted photons with the light-source phase and
// buffers them in per-phase saturating pending counters. Tokens leave one per
// transfer over a valid/ready stream with round-robin phase selection.
//
// Build option: define PMT_GLITCH_FILTER_EN to require MIN_WIDTH consecutive
// synchronized high cycles before an edge becomes a candidate. Without it,
// MIN_WIDTH has no effect and every synchronized rising edge is a candidate.
module pmt_pulse_conditioner #(
  parameter int DEAD_TIME = 4,
  parameter int MIN_WIDTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             PMT_in,
  input  logic             light_source_flag,
  input  logic             clear_flags,
  output logic             pulse_valid,
  output logic             pulse_phase,
  input  logic             pulse_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] dropped_count
);

  localparam int               DEAD_W   = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LD  = DEAD_W'(DEAD_TIME);
  localparam logic [DEAD_W-1:0] DEAD_ONE = DEAD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // Synchronizer and edge candidate
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic cand;

  // Dead time and edge disposition
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic              accept;
  logic              reject;

  // Pending counters and output token
  logic [CNT_W-1:0] pend_on_q, pend_on_d;
  logic [CNT_W-1:0] pend_off_q, pend_off_d;
  logic             valid_q, valid_d;
  logic             phase_q, phase_d;
  logic             last_on_q, last_on_d;
  logic             can_load, sel_on, load_on, load_off;
  logic             inc_on, inc_off, ovf_evt;

  // Status flags
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] dropped_q, dropped_d;

  // Two-stage synchronizer on the asynchronous PMT input
  always_comb begin
    sync1_d = PMT_in;
    sync2_d = sync1_q;
  end

`ifdef PMT_GLITCH_FILTER_EN
  localparam int               RUN_W   = (MIN_WIDTH > 1) ? $clog2(MIN_WIDTH + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_WIDTH);
  localparam logic [RUN_W-1:0] RUN_HIT = RUN_W'(MIN_WIDTH - 1);
  logic [RUN_W-1:0] run_q, run_d;

  // Count consecutive synchronized-high cycles; candidate when the run reaches MIN_WIDTH
  always_comb begin
    run_d = '0;
    if (sync2_q) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    end
    cand = sync2_q && (run_q == RUN_HIT);
  end

  // Run-length register for the glitch filter
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end
`else
  logic prev_q, prev_d;
  logic unused_min_width;
  assign unused_min_width = (MIN_WIDTH > 0);

  // Rising edge of the synchronized level against its previous value
  always_comb begin
    prev_d = sync2_q;
    cand   = sync2_q & ~prev_q;
  end

  // Previous synchronized level
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end
`endif

  // Dead-time window: accept only when the counter has run out, reload on accept
  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    dead_d = dead_q;
    if (dead_q != '0) begin
      dead_d = dead_q - DEAD_ONE;
    end
    if (cand) begin
      if (dead_q == '0) begin
        accept = 1'b1;
        dead_d = DEAD_LD;
      end else begin
        reject = 1'b1;
      end
    end
  end

  // Round-robin token selection, pending counter update and output register load
  always_comb begin
    can_load = ~valid_q | pulse_ready;
    // On wins when it is the only nonzero counter or when off was loaded last
    sel_on   = (pend_on_q != '0) && ((pend_off_q == '0) || !last_on_q);
    load_on  = can_load && sel_on;
    load_off = can_load && !sel_on && (pend_off_q != '0);
    inc_on   = accept & light_source_flag;
    inc_off  = accept & ~light_source_flag;
    ovf_evt  = 1'b0;

    pend_on_d = pend_on_q;
    if (inc_on && !load_on) begin
      if (pend_on_q == CNT_MAX) ovf_evt = 1'b1;
      else                      pend_on_d = pend_on_q + CNT_ONE;
    end else if (load_on && !inc_on) begin
      pend_on_d = pend_on_q - CNT_ONE;
    end

    pend_off_d = pend_off_q;
    if (inc_off && !load_off) begin
      if (pend_off_q == CNT_MAX) ovf_evt = 1'b1;
      else                       pend_off_d = pend_off_q + CNT_ONE;
    end else if (load_off && !inc_off) begin
      pend_off_d = pend_off_q - CNT_ONE;
    end

    valid_d   = valid_q;
    phase_d   = phase_q;
    last_on_d = last_on_q;
    if (can_load) begin
      valid_d = load_on | load_off;
    end
    if (load_on | load_off) begin
      phase_d   = load_on;
      last_on_d = load_on;
    end
  end

  // Sticky overflow and saturating drop count; a same-cycle event beats clear
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_evt)          overflow_d = 1'b1;
    else if (clear_flags) overflow_d = 1'b0;

    dropped_d = dropped_q;
    if (reject) begin
      if (clear_flags)                dropped_d = CNT_ONE;
      else if (dropped_q != CNT_MAX)  dropped_d = dropped_q + CNT_ONE;
    end else if (clear_flags) begin
      dropped_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      dead_q     <= '0;
      pend_on_q  <= '0;
      pend_off_q <= '0;
      valid_q    <= 1'b0;
      phase_q    <= 1'b0;
      last_on_q  <= 1'b0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      dead_q     <= dead_d;
      pend_on_q  <= pend_on_d;
      pend_off_q <= pend_off_d;
      valid_q    <= valid_d;
      phase_q    <= phase_d;
      last_on_q  <= last_on_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  assign pulse_valid   = valid_q;
  assign pulse_phase   = phase_q;
  assign overflow      = overflow_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_pmt_pulse_conditioner.sv
// Testbench for pmt_pulse_conditioner: two instances (CNT_W=16 and CNT_W=2)
// share one stimulus stream and are compared every cycle against an
// event-level reference model, plus directed checks with fixed expectations.
module tb_pmt_pulse_conditioner;

  localparam int DEAD = 4;
  localparam int MINW = 2;
`ifdef PMT_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pmt, flag, clr, rdy;
  logic        va, pa, ova;
  logic [15:0] dca;
  logic        vb, pb, ovb;
  logic [1:0]  dcb;

  always #5 clk = ~clk;

  pmt_pulse_conditioner #(.DEAD_TIME(DEAD), .MIN_WIDTH(MINW), .CNT_W(16)) dut_a (
    .clock_in(clk), .reset(rst), .PMT_in(pmt), .light_source_flag(flag),
    .clear_flags(clr), .pulse_valid(va), .pulse_phase(pa), .pulse_ready(rdy),
    .overflow(ova), .dropped_count(dca));

  pmt_pulse_conditioner #(.DEAD_TIME(DEAD), .MIN_WIDTH(MINW), .CNT_W(2)) dut_b (
    .clock_in(clk), .reset(rst), .PMT_in(pmt), .light_source_flag(flag),
    .clear_flags(clr), .pulse_valid(vb), .pulse_phase(pb), .pulse_ready(rdy),
    .overflow(ovb), .dropped_count(dcb));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit hist [0:8191];      // PMT value sampled at each clock edge since reset
  int n;                  // index of the latest sampled edge
  int last_acc;           // edge index of the last accepted photon, -1 if none
  int max_c   [2] = '{65535, 3};
  int m_on    [2];
  int m_off   [2];
  int m_drop  [2];
  bit m_valid [2];
  bit m_phase [2];
  bit m_last_on [2];
  bit m_ovf   [2];
  bit obs_a [$];
  bit obs_b [$];

  task automatic model_reset();
    for (int k = 0; k < 8192; k++) hist[k] = 1'b0;
    n = 4;
    last_acc = -1;
    for (int i = 0; i < 2; i++) begin
      m_on[i] = 0; m_off[i] = 0; m_drop[i] = 0;
      m_valid[i] = 0; m_phase[i] = 0; m_last_on[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step();
    bit cand, acc, drp, can, ld_on, ld_off, inc_on, inc_off, oset;
    int run;
    if (rst) begin
      model_reset();
      return;
    end
    n++;
    hist[n] = pmt;
    // the edge logic sees the level sampled two edges ago
    if (FILT != 0) begin
      run = 0;
      for (int k = n - 2; k >= 0 && hist[k] && run <= MINW; k--) run++;
      cand = (run == MINW);
    end else begin
      cand = hist[n-2] && !hist[n-3];
    end
    acc = 0; drp = 0;
    if (cand) begin
      if (last_acc < 0 || (n - last_acc) > DEAD) begin
        acc = 1; last_acc = n;
      end else begin
        drp = 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      can    = !m_valid[i] || rdy;
      ld_on  = can && (m_on[i] > 0) && ((m_off[i] == 0) || !m_last_on[i]);
      ld_off = can && !ld_on && (m_off[i] > 0);
      if (can) m_valid[i] = ld_on || ld_off;
      if (ld_on || ld_off) begin
        m_phase[i] = ld_on;
        m_last_on[i] = ld_on;
      end
      inc_on  = acc && flag;
      inc_off = acc && !flag;
      oset = 0;
      if (inc_on && !ld_on && m_on[i] == max_c[i]) oset = 1;
      else m_on[i] = m_on[i] + int'(inc_on) - int'(ld_on);
      if (inc_off && !ld_off && m_off[i] == max_c[i]) oset = 1;
      else m_off[i] = m_off[i] + int'(inc_off) - int'(ld_off);
      if (oset) m_ovf[i] = 1;
      else if (clr) m_ovf[i] = 0;
      if (drp) m_drop[i] = clr ? 1 : ((m_drop[i] == max_c[i]) ? m_drop[i] : m_drop[i] + 1);
      else if (clr) m_drop[i] = 0;
    end
  endtask

  task automatic compare();
    check("a_valid", va, m_valid[0]);
    check("a_phase", pa, m_phase[0]);
    check("a_ovf",   ova, m_ovf[0]);
    check("a_drop",  dca, m_drop[0]);
    check("b_valid", vb, m_valid[1]);
    check("b_phase", pb, m_phase[1]);
    check("b_ovf",   ovb, m_ovf[1]);
    check("b_drop",  dcb, m_drop[1]);
  endtask

  // One clock: log transfers, advance model at the edge, compare on the falling edge
  task automatic tick();
    if (va && rdy && !rst) begin
      obs_a.push_back(pa);
      $display("token a phase=%0d t=%0t", pa, $time);
    end
    if (vb && rdy && !rst) obs_b.push_back(pb);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic apply_reset();
    rst = 1; pmt = 0; flag = 0; clr = 0; rdy = 0;
    #1;
    model_reset();
    repeat (2) tick();
    rst = 0;
    obs_a.delete();
    obs_b.delete();
  endtask

  // One photon slot: pulse wide enough to pass the filter, spaced beyond dead time
  task automatic photon(input bit ph);
    flag = ph;
    pmt = 1;
    repeat (FILT != 0 ? MINW : 1) tick();
    pmt = 0;
    repeat (6) tick();
  endtask

  int first_k, vcnt;
  bit exp_ord [8] = '{1, 0, 1, 0, 1, 0, 1, 1};
  bit ord_ph  [8] = '{1, 0, 1, 0, 1, 1, 0, 1};

  initial begin
    rst = 1; pmt = 0; flag = 0; clr = 0; rdy = 0;
    apply_reset();
    check("reset_valid", va, 0);
    check("reset_phase", pa, 0);
    check("reset_ovf",   ova, 0);
    check("reset_drop",  dca, 0);

    // latency: 3-cycle pulse, on phase, consumer always ready
    rdy = 1; flag = 1; pmt = 1;
    first_k = -1; vcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 4) pmt = 0;
      tick();
      if (va) begin
        vcnt++;
        if (first_k < 0) begin
          first_k = k;
          check("lat_phase", pa, 1);
        end
      end
    end
    check("lat_cycles", first_k, 4 + FILT * (MINW - 1));
    check("lat_width", vcnt, 1);

    // dead time: a pulse every 2 cycles, 10 pulses
    apply_reset();
    rdy = 1;
    for (int p = 0; p < 10; p++) begin
      pmt = 1; tick();
      pmt = 0; tick();
    end
    repeat (10) tick();
    if (FILT == 0) begin
      check("dead_tokens", obs_a.size(), 4);
      check("dead_drop_a", dca, 6);
      check("dead_drop_b_sat", dcb, 3);
    end
    clr = 1; tick(); clr = 0;
    check("clear_drop", dca, 0);

    // stall ordering: 5 on and 3 off pending, then release
    apply_reset();
    for (int p = 0; p < 8; p++) begin
      photon(ord_ph[p]);
      check("stall_valid", va, 1);
      check("stall_phase", pa, 1);
    end
    rdy = 1;
    repeat (20) tick();
    check("order_count", obs_a.size(), 8);
    for (int p = 0; p < 8 && p < obs_a.size(); p++) check($sformatf("order_%0d", p), obs_a[p], exp_ord[p]);

    // saturation on the narrow instance
    apply_reset();
    for (int p = 0; p < 5; p++) photon(1'b1);
    check("sat_ovf_b", ovb, 1);
    check("sat_ovf_a", ova, 0);
    rdy = 1;
    repeat (20) tick();
    check("sat_tokens_b", obs_b.size(), 4);
    check("sat_tokens_a", obs_a.size(), 5);

    // width filtering: 1-cycle then 2-cycle pulse
    apply_reset();
    rdy = 1; flag = 0;
    pmt = 1; tick(); pmt = 0; repeat (8) tick();
    check("short_pulse", obs_a.size(), (FILT != 0) ? 0 : 1);
    obs_a.delete();
    pmt = 1; repeat (2) tick(); pmt = 0; repeat (8) tick();
    check("wide_pulse", obs_a.size(), 1);

    // reset while tokens are pending
    apply_reset();
    for (int p = 0; p < 3; p++) photon(p[0]);
    check("pre_rst_valid", va, 1);
    #2 rst = 1;
    #1;
    check("rst_async_valid", va, 0);
    check("rst_async_valid_b", vb, 0);
    model_reset();
    @(negedge clk);
    repeat (2) tick();
    rst = 0; rdy = 1;
    repeat (20) tick();
    check("post_rst_tokens", obs_a.size(), 0);

    // randomized traffic, long stalls to exercise saturation
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) pmt = ~pmt;
      flag = 1'($urandom_range(0, 1));
      rdy  = ((c % 400) < 150) ? 1'b0 : ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 63) == 0);
      if (c == 1500) apply_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
